pll_lock_sequencer: RTL and testbench
=====================================

# pll_lock_sequencer

Reset and lock sequencer for the 50 MHz → 25/125 MHz video PLL: pulses the PLL reset, waits for lock with timeout and bounded retry, and qualifies lock stability before releasing the downstream video reset. Runs on the PLL reference clock, so it keeps working while the PLL outputs are absent. It drives the PLL `rst` input and consumes its `locked` output.

## Interface
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per reset attempt (≥1).
- `LOCK_TIMEOUT`, 50000: cycles allowed in WAIT_LOCK before an attempt counts as failed (1 ms at 50 MHz).
- `STABLE_CYCLES`, 256: consecutive synchronized-locked cycles required before release.
- `MAX_RETRIES`, 3: failed attempts before entering FAIL (1..15).
- `CNT_W`, 16: width of the shared cycle counter; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- `refclk` in 1: 50 MHz reference clock.
- `rst_n` in 1: asynchronous reset, active low.
- `pll_locked` in 1: PLL lock, asynchronous to `refclk`.
- `restart` in 1: synchronous one-cycle request to re-run the full sequence.
- `pll_rst` out 1: PLL reset, active high.
- `sys_rst_n` out 1: downstream reset, active low, registered.
- `lock_ok` out 1: high only in RUN.
- `fail` out 1: high only in FAIL.
- `retry_cnt` out 4: failed attempts in the current sequence.
- `state` out 3: current state encoding.
- `loss_cnt` out 8: loss-of-lock events; see Configuration.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to form `lk_s`. All decisions use `lk_s`.
- States and encodings: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- RESET_PLL: `pll_rst`=1. The counter counts to RST_CYCLES, then the block enters WAIT_LOCK with the counter cleared.
- WAIT_LOCK: `pll_rst`=0.
  - `lk_s`=1 → STABLE with the counter cleared.
  - Counter reaches LOCK_TIMEOUT-1 without lock → `retry_cnt`+1. If the new value equals MAX_RETRIES the block enters FAIL; otherwise it enters RESET_PLL.
- STABLE: the counter increments while `lk_s`=1.
  - `lk_s`=0 → WAIT_LOCK with the timeout counter cleared. `retry_cnt` is unchanged.
  - Count reaches STABLE_CYCLES → RUN and `retry_cnt` clears.
- RUN: `sys_rst_n`=1 and `lock_ok`=1. `lk_s`=0 → RESET_PLL, which counts as a loss-of-lock event. `retry_cnt` is not incremented.
- FAIL: `pll_rst`=1, `fail`=1, `sys_rst_n`=0. Only `restart` or `rst_n` leaves FAIL.
- `restart`=1 in any state → RESET_PLL with the counter and `retry_cnt` cleared.
  - It takes priority over every other transition in the same cycle.
  - `restart` held high keeps the block in RESET_PLL.
- `sys_rst_n` is 0 in every state except RUN.
- Illegal state encodings return to RESET_PLL.

## Timing
- Reset values: `pll_rst`=1, `sys_rst_n`=0, `lock_ok`=0, `fail`=0, `retry_cnt`=0, `state`=0, `loss_cnt`=0, synchronizer flops=0, counter=0.
- All outputs are registered and change on the cycle the state is entered.
- Lock detection latency: 2 synchronizer cycles plus 1 state-register cycle.
- Release latency from a clean `pll_locked` rise in WAIT_LOCK: 3 + STABLE_CYCLES cycles to `sys_rst_n`=1.
- Lock-loss latency: `pll_locked` falls → `sys_rst_n`=0 and `pll_rst`=1 three cycles later.
- `rst_n` asserted mid-sequence forces the reset values immediately. Deassertion is followed by a full RESET_PLL phase.
- `lk_s` rising in the last WAIT_LOCK cycle takes priority over the timeout: the block enters STABLE and no retry is counted.

## Configuration
- `PLL_SEQ_LOSS_CNT_EN` defined: `loss_cnt` increments on each RUN→RESET_PLL transition caused by `lk_s`=0.
  - It saturates at 255.
  - It clears only on `rst_n`, not on `restart`.
- Undefined: `loss_cnt` is tied to 0 and the counter logic is not compiled in.

## Test plan
Use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
- Clean lock: release `rst_n`, then raise `pll_locked` at cycle 10.
  - `pll_rst` is high for exactly 4 cycles.
  - `sys_rst_n`=1 and `lock_ok`=1 at cycle 21; `retry_cnt`=0.
- No lock: `pll_locked` held at 0.
  - Two RESET_PLL/WAIT_LOCK rounds occur, then FAIL: `fail`=1, `retry_cnt`=2, `pll_rst`=1, `state`=4.
  - A `restart` pulse then returns the block to `state`=0 with `retry_cnt`=0.
- Glitchy lock: in STABLE, drop `pll_locked` for 3 cycles after 5 high cycles.
  - The block returns to WAIT_LOCK with no retry counted.
  - After a later stable high, `sys_rst_n` rises only after 8 consecutive `lk_s` cycles.
- Loss in RUN: drop `pll_locked` while in RUN.
  - `sys_rst_n`=0 and `pll_rst`=1 three cycles later.
  - `loss_cnt`=1 with the macro defined, 0 without it.
- Restart priority: assert `restart` on the same cycle the STABLE count completes. The next state is RESET_PLL, not RUN.
- Async reset: assert `rst_n` in RUN. All outputs take their reset values without a clock edge.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer on refclk: pulses pll_rst, waits for lock with timeout/retry, qualifies stability, then releases sys_rst_n.
// Optional macro PLL_SEQ_LOSS_CNT_EN enables the saturating loss-of-lock counter on loss_cnt.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 16
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       lock_ok,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state,
  output logic [7:0] loss_cnt
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  logic             sync1;
  logic             lk_s;
  state_t           st;
  state_t           st_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [3:0]       retry_nxt;

  // pll_locked is asynchronous to refclk
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      lk_s  <= 1'b0;
    end else begin
      sync1 <= pll_locked;
      lk_s  <= sync1;
    end
  end

  always_comb begin
    st_nxt    = st;
    cnt_nxt   = cnt;
    retry_nxt = retry_cnt;
    if (restart) begin
      st_nxt    = S_RESET_PLL;
      cnt_nxt   = '0;
      retry_nxt = '0;
    end else begin
      case (st)
        S_RESET_PLL: begin
          if (cnt == RST_LAST) begin
            st_nxt  = S_WAIT_LOCK;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          // lock seen on the final timeout cycle still wins over the retry
          if (lk_s) begin
            st_nxt  = S_STABLE;
            cnt_nxt = '0;
          end else if (cnt == TMO_LAST) begin
            retry_nxt = retry_cnt + 4'd1;
            cnt_nxt   = '0;
            st_nxt    = (retry_cnt + 4'd1 == RETRY_MAX) ? S_FAIL : S_RESET_PLL;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_STABLE: begin
          if (!lk_s) begin
            st_nxt  = S_WAIT_LOCK;
            cnt_nxt = '0;
          end else if (cnt == STB_LAST) begin
            st_nxt    = S_RUN;
            cnt_nxt   = '0;
            retry_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!lk_s) begin
            st_nxt  = S_RESET_PLL;
            cnt_nxt = '0;
          end
        end
        S_FAIL: ;
        default: begin
          st_nxt  = S_RESET_PLL;
          cnt_nxt = '0;
        end
      endcase
    end
  end

  // outputs decode the next state so they change on the cycle the state is entered
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_RESET_PLL;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      lock_ok   <= 1'b0;
      fail      <= 1'b0;
    end else begin
      st        <= st_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      pll_rst   <= (st_nxt == S_RESET_PLL) || (st_nxt == S_FAIL);
      sys_rst_n <= (st_nxt == S_RUN);
      lock_ok   <= (st_nxt == S_RUN);
      fail      <= (st_nxt == S_FAIL);
    end
  end

  assign state = st;

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic loss_evt;
  assign loss_evt = (st == S_RUN) && !lk_s && !restart;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt <= '0;
    end else if (loss_evt && (loss_cnt != 8'hFF)) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end
`else
  assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
module tb_pll_lock_sequencer;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       lock_ok;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [2:0] state;
  logic [7:0] loss_cnt;

  int checks = 0;
  int fails  = 0;

`ifdef PLL_SEQ_LOSS_CNT_EN
  localparam logic [7:0] LOSS_EXP = 8'd1;
`else
  localparam logic [7:0] LOSS_EXP = 8'd0;
`endif

  pll_lock_sequencer #(
    .RST_CYCLES(4),
    .LOCK_TIMEOUT(20),
    .STABLE_CYCLES(8),
    .MAX_RETRIES(2),
    .CNT_W(16)
  ) dut (
    .refclk(refclk),
    .rst_n(rst_n),
    .pll_locked(pll_locked),
    .restart(restart),
    .pll_rst(pll_rst),
    .sys_rst_n(sys_rst_n),
    .lock_ok(lock_ok),
    .fail(fail),
    .retry_cnt(retry_cnt),
    .state(state),
    .loss_cnt(loss_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // inputs are driven and outputs sampled 1 time unit after each rising edge
  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_locked = 1'b0; restart = 1'b0;
    repeat (3) step();
    checks++; if (pll_rst !== 1'b1) begin fails++; $display("FAIL reset_pll_rst act=%b exp=1", pll_rst); end
    checks++; if (sys_rst_n !== 1'b0) begin fails++; $display("FAIL reset_sys_rst_n act=%b exp=0", sys_rst_n); end
    checks++; if (lock_ok !== 1'b0 || fail !== 1'b0) begin fails++; $display("FAIL reset_flags lock_ok=%b fail=%b exp=0/0", lock_ok, fail); end
    checks++; if (state !== 3'd0 || retry_cnt !== 4'd0 || loss_cnt !== 8'd0) begin
      fails++; $display("FAIL reset_regs state=%0d retry=%0d loss=%0d exp=0/0/0", state, retry_cnt, loss_cnt);
    end
  endtask

  task automatic test_clean_lock();
    int rst_hi = 0;
    rst_n = 1'b1;
    for (int c = 0; c <= 21; c++) begin
      if (pll_rst) rst_hi++;
      if (c == 4) begin
        checks++; if (state !== 3'd1) begin fails++; $display("FAIL clean_wait_state c=4 act=%0d exp=1", state); end
      end
      if (c == 13) begin
        checks++; if (state !== 3'd2) begin fails++; $display("FAIL clean_stable_state c=13 act=%0d exp=2", state); end
      end
      if (c == 20) begin
        checks++; if (sys_rst_n !== 1'b0) begin fails++; $display("FAIL clean_early_release c=20 act=%b exp=0", sys_rst_n); end
      end
      if (c == 21) begin
        checks++; if (sys_rst_n !== 1'b1 || lock_ok !== 1'b1) begin
          fails++; $display("FAIL clean_release c=21 sys_rst_n=%b lock_ok=%b exp=1/1", sys_rst_n, lock_ok);
        end
        checks++; if (retry_cnt !== 4'd0 || state !== 3'd3) begin
          fails++; $display("FAIL clean_run c=21 retry=%0d state=%0d exp=0/3", retry_cnt, state);
        end
      end
      if (c == 10) pll_locked = 1'b1;
      if (c < 21) step();
    end
    checks++; if (rst_hi != 4) begin fails++; $display("FAIL clean_pll_rst_width act=%0d exp=4", rst_hi); end
  endtask

  task automatic test_loss_in_run();
    pll_locked = 1'b0;
    step(); step();
    checks++; if (sys_rst_n !== 1'b1) begin fails++; $display("FAIL loss_early act=%b exp=1", sys_rst_n); end
    step();
    checks++; if (sys_rst_n !== 1'b0 || pll_rst !== 1'b1 || lock_ok !== 1'b0) begin
      fails++; $display("FAIL loss_outputs sys_rst_n=%b pll_rst=%b lock_ok=%b exp=0/1/0", sys_rst_n, pll_rst, lock_ok);
    end
    checks++; if (state !== 3'd0 || retry_cnt !== 4'd0) begin
      fails++; $display("FAIL loss_state state=%0d retry=%0d exp=0/0", state, retry_cnt);
    end
    checks++; if (loss_cnt !== LOSS_EXP) begin fails++; $display("FAIL loss_cnt act=%0d exp=%0d", loss_cnt, LOSS_EXP); end
  endtask

  task automatic test_no_lock();
    pll_locked = 1'b0;
    pulse_restart();
    for (int c = 0; c <= 48; c++) begin
      if (c == 23) begin
        checks++; if (state !== 3'd1 || retry_cnt !== 4'd0) begin
          fails++; $display("FAIL nolock_c23 state=%0d retry=%0d exp=1/0", state, retry_cnt);
        end
      end
      if (c == 24) begin
        checks++; if (state !== 3'd0 || retry_cnt !== 4'd1 || pll_rst !== 1'b1) begin
          fails++; $display("FAIL nolock_retry1 state=%0d retry=%0d pll_rst=%b exp=0/1/1", state, retry_cnt, pll_rst);
        end
      end
      if (c == 47) begin
        checks++; if (state !== 3'd1 || fail !== 1'b0) begin
          fails++; $display("FAIL nolock_c47 state=%0d fail=%b exp=1/0", state, fail);
        end
      end
      if (c == 48) begin
        checks++; if (state !== 3'd4 || fail !== 1'b1 || retry_cnt !== 4'd2) begin
          fails++; $display("FAIL nolock_fail state=%0d fail=%b retry=%0d exp=4/1/2", state, fail, retry_cnt);
        end
        checks++; if (pll_rst !== 1'b1 || sys_rst_n !== 1'b0) begin
          fails++; $display("FAIL nolock_fail_rst pll_rst=%b sys_rst_n=%b exp=1/0", pll_rst, sys_rst_n);
        end
      end
      if (c < 48) step();
    end
    repeat (5) step();
    checks++; if (state !== 3'd4) begin fails++; $display("FAIL nolock_sticky act=%0d exp=4", state); end
    pulse_restart();
    checks++; if (state !== 3'd0 || retry_cnt !== 4'd0 || fail !== 1'b0 || pll_rst !== 1'b1) begin
      fails++; $display("FAIL nolock_restart state=%0d retry=%0d fail=%b pll_rst=%b exp=0/0/0/1", state, retry_cnt, fail, pll_rst);
    end
    checks++; if (loss_cnt !== LOSS_EXP) begin fails++; $display("FAIL restart_keeps_loss act=%0d exp=%0d", loss_cnt, LOSS_EXP); end
    restart = 1'b1;
    repeat (6) step();
    checks++; if (state !== 3'd0 || pll_rst !== 1'b1) begin
      fails++; $display("FAIL restart_held state=%0d pll_rst=%b exp=0/1", state, pll_rst);
    end
    restart = 1'b0;
  endtask

  task automatic test_glitch();
    pll_locked = 1'b0;
    pulse_restart();
    for (int c = 0; c <= 25; c++) begin
      if (c == 9 || c == 13) begin
        checks++; if (state !== 3'd2) begin fails++; $display("FAIL glitch_stable c=%0d act=%0d exp=2", c, state); end
      end
      if (c == 14 || c == 16) begin
        checks++; if (state !== 3'd1 || retry_cnt !== 4'd0) begin
          fails++; $display("FAIL glitch_back_to_wait c=%0d state=%0d retry=%0d exp=1/0", c, state, retry_cnt);
        end
      end
      if (c == 24) begin
        checks++; if (state !== 3'd2 || sys_rst_n !== 1'b0) begin
          fails++; $display("FAIL glitch_early c=24 state=%0d sys_rst_n=%b exp=2/0", state, sys_rst_n);
        end
      end
      if (c == 25) begin
        checks++; if (state !== 3'd3 || sys_rst_n !== 1'b1) begin
          fails++; $display("FAIL glitch_release c=25 state=%0d sys_rst_n=%b exp=3/1", state, sys_rst_n);
        end
      end
      if (c == 6)  pll_locked = 1'b1;
      if (c == 11) pll_locked = 1'b0;
      if (c == 14) pll_locked = 1'b1;
      if (c < 25) step();
    end
  endtask

  task automatic test_restart_priority();
    pll_locked = 1'b1;
    pulse_restart();
    for (int c = 0; c <= 12; c++) begin
      if (c == 5 || c == 12) begin
        checks++; if (state !== 3'd2) begin fails++; $display("FAIL prio_stable c=%0d act=%0d exp=2", c, state); end
      end
      if (c < 12) step();
    end
    restart = 1'b1;
    step();
    restart = 1'b0;
    checks++; if (state !== 3'd0 || sys_rst_n !== 1'b0 || lock_ok !== 1'b0) begin
      fails++; $display("FAIL prio_restart state=%0d sys_rst_n=%b lock_ok=%b exp=0/0/0", state, sys_rst_n, lock_ok);
    end
  endtask

  task automatic test_async_reset();
    int rst_hi = 0;
    for (int i = 0; i < 40 && state !== 3'd3; i++) step();
    checks++; if (state !== 3'd3) begin fails++; $display("FAIL async_reach_run act=%0d exp=3", state); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pll_rst !== 1'b1 || sys_rst_n !== 1'b0 || lock_ok !== 1'b0 || fail !== 1'b0) begin
      fails++; $display("FAIL async_outputs pll_rst=%b sys_rst_n=%b lock_ok=%b fail=%b exp=1/0/0/0", pll_rst, sys_rst_n, lock_ok, fail);
    end
    checks++; if (state !== 3'd0 || retry_cnt !== 4'd0 || loss_cnt !== 8'd0) begin
      fails++; $display("FAIL async_regs state=%0d retry=%0d loss=%0d exp=0/0/0", state, retry_cnt, loss_cnt);
    end
    step();
    rst_n = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      if (pll_rst) rst_hi++;
      if (c < 4) step();
    end
    checks++; if (rst_hi != 4 || state !== 3'd1) begin
      fails++; $display("FAIL async_rerun pll_rst_cycles=%0d state=%0d exp=4/1", rst_hi, state);
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_loss_in_run();
    test_no_lock();
    test_glitch();
    test_restart_priority();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
